// File: rtl/dec_timer_ctrl.sv
// dec_timer_ctrl: prescaled down-counter controller that drives an external
// decrementer and captures its result on each tick; one-shot or periodic expiry.
`default_nettype none

module dec_timer_ctrl #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  pause,
  input  logic                  periodic,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  load_valid,
  input  logic [WIDTH-1:0]      load_data,
  output logic                  load_ready,
  output logic [WIDTH-1:0]      dec_a,
  input  logic [WIDTH-1:0]      dec_diff,
  output logic [WIDTH-1:0]      count,
  output logic                  running,
  output logic                  expire
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [WIDTH-1:0]      period, period_nxt;
  logic [WIDTH-1:0]      count_nxt;
  logic [PRESCALE_W-1:0] psc, psc_nxt;
  logic                  expire_nxt;
  logic                  load_accept;
  logic [WIDTH-1:0]      eff_period;
  logic                  advance;

  assign load_ready  = (state != RUN);
  assign running     = (state == RUN);
  assign dec_a       = count;
  assign load_accept = load_valid && load_ready;
  assign eff_period  = load_accept ? load_data : period;

  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    psc_nxt    = psc;
    expire_nxt = 1'b0;
    period_nxt = eff_period;
    advance    = 1'b0;

    case (state)
      IDLE: begin
        if (start && (eff_period != '0)) begin
          count_nxt = eff_period;
          psc_nxt   = '0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (start) begin
          // A zero period (loaded while paused) cannot be restarted into RUN.
          psc_nxt = '0;
          if (period != '0) begin
            count_nxt = period;
          end else begin
            count_nxt = '0;
            state_nxt = IDLE;
          end
        end else if (pause) begin
          state_nxt = PAUSE;
        end else begin
          advance = 1'b1;
        end
      end
      PAUSE: begin
        // Resuming cycle already counts, so the delay equals the paused cycles.
        if (!pause) begin
          state_nxt = RUN;
          advance   = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = '0;
        psc_nxt   = '0;
      end
    endcase

    if (advance) begin
      if (psc == prescale) begin
        psc_nxt = '0;
        if (count != WIDTH'(1)) begin
          count_nxt = dec_diff;
        end else begin
          expire_nxt = 1'b1;
          if (periodic && (period != '0)) begin
            count_nxt = period;
            state_nxt = RUN;
          end else begin
            count_nxt = '0;
            state_nxt = IDLE;
          end
        end
      end else begin
        psc_nxt = psc + PRESCALE_W'(1);
      end
    end

    if (stop) begin
      state_nxt  = IDLE;
      count_nxt  = '0;
      psc_nxt    = '0;
      expire_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      period <= '0;
      count  <= '0;
      psc    <= '0;
      expire <= 1'b0;
    end else begin
      state  <= state_nxt;
      period <= period_nxt;
      count  <= count_nxt;
      psc    <= psc_nxt;
      expire <= expire_nxt;
    end
  end

endmodule

`default_nettype wire
